// File: rtl/buf_access_ctrl_if.sv
// rtl/buf_access_ctrl_if.sv - request, grant and buffer-port bundle between the requesters and buf_access_ctrl
interface buf_access_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              req0;
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req0_len;
    logic              req0_wr;
    logic              req1;
    logic [ADDR_W-1:0] req1_addr;
    logic [ADDR_W-1:0] req1_len;
    logic              req1_wr;
    logic              hold;

    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic              busy;
    logic              owner;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_we;

    // Requester side: issues bursts and stalls, watches grants and the buffer port.
    modport master (
        output req0, req0_addr, req0_len, req0_wr,
        output req1, req1_addr, req1_len, req1_wr,
        output hold,
        input  gnt0, gnt1, done0, done1, busy, owner,
        input  mem_addr, mem_en, mem_we
    );

    // Controller side.
    modport slave (
        input  req0, req0_addr, req0_len, req0_wr,
        input  req1, req1_addr, req1_len, req1_wr,
        input  hold,
        output gnt0, gnt1, done0, done1, busy, owner,
        output mem_addr, mem_en, mem_we
    );
endinterface

// File: rtl/buf_access_ctrl.sv
// rtl/buf_access_ctrl.sv - two-requester burst arbiter and address sequencer for the shared operand buffer
// Define BUF_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module buf_access_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    buf_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              wr_q;
    logic              owner_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              done0_q;
    logic              done1_q;
    logic              busy_q;

    logic              any_req;
    logic              winner;
    logic              access;

    assign any_req = bus.req0 | bus.req1;

`ifdef BUF_CTRL_RR_EN
    // rr_ptr names the requester that wins a tie; it flips away from each winner.
    logic rr_ptr;

    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = rr_ptr;
        end else begin
            winner = bus.req1;
        end
    end
`else
    always_comb begin
        winner = ~bus.req0;
    end
`endif

    // A hold cycle inside a burst simply suppresses the access; the address waits.
    assign access = (state == BURST) && !bus.hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BUF_CTRL_RR_EN
            rr_ptr  <= 1'b0;
`endif
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        addr_q  <= winner ? bus.req1_addr : bus.req0_addr;
                        len_q   <= winner ? bus.req1_len  : bus.req0_len;
                        wr_q    <= winner ? bus.req1_wr   : bus.req0_wr;
                        cnt_q   <= '0;
                        owner_q <= winner;
                        gnt0_q  <= ~winner;
                        gnt1_q  <= winner;
                        busy_q  <= 1'b1;
                        state   <= BURST;
`ifdef BUF_CTRL_RR_EN
                        rr_ptr  <= ~winner;
`endif
                    end
                end

                BURST: begin
                    if (access) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (cnt_q == len_q) begin
                            done0_q <= ~owner_q;
                            done1_q <= owner_q;
                            state   <= DONE;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end

                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_en   = access;
    assign bus.mem_we   = access & wr_q;
endmodule

// File: tb/tb_buf_access_ctrl.sv
// tb/tb_buf_access_ctrl.sv - randomized self-checking bench for buf_access_ctrl
module tb_buf_access_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    buf_access_ctrl_if #(.ADDR_W(9)) bus ();

    buf_access_ctrl #(.ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.req0_addr = '0; bus.req0_len = '0; bus.req0_wr = 1'b0;
        bus.req1 = 1'b0; bus.req1_addr = '0; bus.req1_len = '0; bus.req1_wr = 1'b0;
        bus.hold = 1'b0;
    endtask

    // One burst from a single requester. Expected behaviour is tracked as "words
    // transferred so far": each unstalled burst cycle moves word n at start+n.
    task automatic run_burst(input bit who, input logic [8:0] start, input logic [8:0] len,
                             input bit wr, input logic [31:0] mask, input string name);
        int         acc;
        int         j;
        int         phase;
        bit         h;
        bit         finished;
        bit         exp_en;
        logic [8:0] exp_addr;

        @(posedge clk); #1;
        bus.req0 = (who == 1'b0); bus.req1 = (who == 1'b1);
        bus.req0_addr = who ? 9'($urandom) : start; bus.req0_len = who ? 9'($urandom) : len;
        bus.req1_addr = who ? start : 9'($urandom); bus.req1_len = who ? len : 9'($urandom);
        bus.req0_wr = who ? 1'($urandom) : wr;     bus.req1_wr = who ? wr : 1'($urandom);
        bus.hold = 1'($urandom);
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
            fails++;
            $display("FAIL %s idle-before busy=%b gnt0=%b gnt1=%b exp 0", name, bus.busy, bus.gnt0, bus.gnt1);
        end

        acc = 0; j = 0; phase = 0; finished = 1'b0;
        for (int c = 1; c <= 700 && !finished; c++) begin
            @(posedge clk); #1;
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            h = (phase == 0) ? ((j < 32) ? mask[j] : 1'b0) : 1'($urandom);
            bus.hold = h;
            @(negedge clk);
            tests++;
            if (bus.gnt0 !== (c == 1 && who == 1'b0) || bus.gnt1 !== (c == 1 && who == 1'b1)) begin
                fails++;
                $display("FAIL %s gnt cyc%0d got gnt0=%b gnt1=%b exp who=%0d first=%0d", name, c, bus.gnt0, bus.gnt1, who, c == 1);
            end
            if (phase == 0) begin
                exp_en   = !h;
                exp_addr = start + 9'(acc);
                tests++;
                if (bus.mem_en !== exp_en || bus.mem_we !== (exp_en & wr)) begin
                    fails++;
                    $display("FAIL %s strobe cyc%0d en=%b we=%b exp en=%b we=%b", name, c, bus.mem_en, bus.mem_we, exp_en, exp_en & wr);
                end
                tests++;
                if (bus.mem_addr !== exp_addr) begin
                    fails++;
                    $display("FAIL %s mem_addr cyc%0d got %0d exp %0d", name, c, bus.mem_addr, exp_addr);
                end
                tests++;
                if (bus.busy !== 1'b1 || bus.owner !== who || bus.done0 !== 1'b0 || bus.done1 !== 1'b0) begin
                    fails++;
                    $display("FAIL %s burst-status cyc%0d busy=%b owner=%b done0=%b done1=%b exp 1 %0d 0 0", name, c, bus.busy, bus.owner, bus.done0, bus.done1, who);
                end
                if (exp_en) acc++;
                j++;
                if (acc == int'(len) + 1) phase = 1;
            end else if (phase == 1) begin
                tests++;
                if (bus.done0 !== (who == 1'b0) || bus.done1 !== (who == 1'b1) || bus.mem_en !== 1'b0 || bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s done cyc%0d done0=%b done1=%b en=%b busy=%b exp who=%0d", name, c, bus.done0, bus.done1, bus.mem_en, bus.busy, who);
                end
                phase = 2;
            end else begin
                tests++;
                if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.mem_en !== 1'b0) begin
                    fails++;
                    $display("FAIL %s idle-after cyc%0d busy=%b done0=%b done1=%b en=%b exp 0", name, c, bus.busy, bus.done0, bus.done1, bus.mem_en);
                end
                finished = 1'b1;
            end
        end
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL %s timeout got unfinished exp idle within budget", name);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1; bus.hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mem_en, bus.mem_we, bus.owner} !== 8'b0
            || bus.mem_addr !== 9'd0) begin
            fails++;
            $display("FAIL reset_state got gnt=%b%b done=%b%b busy=%b en=%b we=%b owner=%b addr=%0d exp all 0",
                     bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mem_en, bus.mem_we, bus.owner, bus.mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        run_burst(1'b1, 9'd10, 9'd3, 1'b0, 32'h0, "single_read");
    endtask

    task automatic test_wrap_write();
        run_burst(1'b0, 9'd510, 9'd3, 1'b1, 32'h0, "wrap_write");
    endtask

    task automatic test_hold();
        run_burst(1'b0, 9'd100, 9'd3, 1'b1, 32'h6, "hold");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_burst(1'($urandom), 9'($urandom), 9'($urandom_range(0, 40)), 1'($urandom),
                      $urandom & $urandom & $urandom, "random");
        end
    endtask

    task automatic test_full_length();
        run_burst(1'b0, 9'd0, 9'd511, 1'b0, 32'h0, "full_length");
    endtask

    // Both requesters held high with one-word bursts: a grant every third cycle.
    task automatic test_contention();
        int  g;
        bit  w;
        bit  last_w;
        test_reset();
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.req0_addr = 9'd100; bus.req0_len = 9'd0; bus.req0_wr = 1'b1;
        bus.req1 = 1'b1; bus.req1_addr = 9'd200; bus.req1_len = 9'd0; bus.req1_wr = 1'b0;
        bus.hold = 1'b0;
        last_w = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            g = (c - 1) / 3;
`ifdef BUF_CTRL_RR_EN
            w = 1'(g % 2);
`else
            w = 1'b0;
`endif
            if (c % 3 == 1) begin
                last_w = w;
                tests++;
                if (bus.gnt0 !== ~w || bus.gnt1 !== w || bus.owner !== w) begin
                    fails++;
                    $display("FAIL contention grant#%0d got gnt0=%b gnt1=%b owner=%b exp winner %0d", g, bus.gnt0, bus.gnt1, bus.owner, w);
                end
                tests++;
                if (bus.mem_en !== 1'b1 || bus.mem_addr !== (w ? 9'd200 : 9'd100) || bus.mem_we !== ~w) begin
                    fails++;
                    $display("FAIL contention access#%0d got en=%b addr=%0d we=%b exp winner %0d", g, bus.mem_en, bus.mem_addr, bus.mem_we, w);
                end
            end else begin
                tests++;
                if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.mem_en !== 1'b0 || bus.owner !== last_w
                    || bus.done0 !== (c % 3 == 2 && !last_w) || bus.done1 !== (c % 3 == 2 && last_w)) begin
                    fails++;
                    $display("FAIL contention cyc%0d got gnt=%b%b en=%b owner=%b done=%b%b exp owner %0d done-cycle %0d",
                             c, bus.gnt0, bus.gnt1, bus.mem_en, bus.owner, bus.done0, bus.done1, last_w, c % 3 == 2);
                end
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.req0_addr = 9'd0; bus.req0_len = 9'd511; bus.req0_wr = 1'b0; bus.hold = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            bus.req0 = 1'b0;
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            tests++;
            if (bus.mem_en !== 1'b1 || bus.mem_addr !== 9'(c - 1)) begin
                fails++;
                $display("FAIL reset_mid access%0d got en=%b addr=%0d exp en=1 addr=%0d", c, bus.mem_en, bus.mem_addr, c - 1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== 9'd0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid after got busy=%b en=%b addr=%0d done=%b%b exp 0", bus.busy, bus.mem_en, bus.mem_addr, bus.done0, bus.done1);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid quiet%0d got done=%b%b busy=%b exp 0", c, bus.done0, bus.done1, bus.busy);
            end
        end
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.req0_addr = 9'd7;  bus.req0_len = 9'd0;
        bus.req1 = 1'b1; bus.req1_addr = 9'd77; bus.req1_len = 9'd0;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        tests++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.owner !== 1'b0 || bus.mem_addr !== 9'd7) begin
            fails++;
            $display("FAIL reset_mid tie got gnt0=%b gnt1=%b owner=%b addr=%0d exp requester 0 addr 7", bus.gnt0, bus.gnt1, bus.owner, bus.mem_addr);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_wrap_write();
        test_hold();
        test_contention();
        test_random();
        test_full_length();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/buf_access_ctrl.md
# buf_access_ctrl

Sequencing and arbitration controller for the shared 512-entry operand buffer of the multiplier datapath. Two requesters, the operand loader (requester 0) and the Newton iteration engine (requester 1), each ask for a burst of consecutive buffer accesses. The block grants one requester at a time and then drives the buffer's 9-bit address, enable and write-enable for that burst. It replaces ad-hoc free-running address counters with a single owned, handshaked address sequencer.

## Interface
Parameters:
- ADDR_W, 9, buffer address and length width (buffer depth 2^ADDR_W = 512)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  burst request, held high until the matching gnt
- req0_addr / req1_addr  in  ADDR_W  burst start address
- req0_len / req1_len  in  ADDR_W  burst length minus one (0 = 1 word, 511 = 512 words)
- req0_wr / req1_wr  in  1  1 = write burst, 0 = read burst
- hold  in  1  stall; while high, no access and no address advance
- gnt0 / gnt1  out  1  one-cycle grant pulse
- done0 / done1  out  1  one-cycle burst-complete pulse
- busy  out  1  high in any state other than IDLE
- owner  out  1  index of the current or last granted requester
- mem_addr  out  ADDR_W  buffer address
- mem_en  out  1  buffer access strobe
- mem_we  out  1  buffer write enable, valid only with mem_en

## Operation
- States are IDLE, BURST and DONE.
- IDLE:
  - If either request is high, the block picks a winner at the clock edge.
  - It captures the winner's addr, len and wr into internal registers.
  - Next state is BURST, and gnt<winner> is high for exactly the first BURST cycle.
  - owner is set to the winner.
- Arbitration:
  - Round-robin, with the last granted requester getting the lower priority (see Configuration).
  - After reset, requester 0 wins the first tie.
- BURST:
  - mem_en = ~hold, combinational from the registered state.
  - mem_we = mem_en & captured wr.
  - mem_addr = registered address. The address advances by 1 modulo 512 on each edge where mem_en = 1, so 511 wraps to 0.
  - An internal word counter increments on each access.
  - At the edge where mem_en = 1 and counter == captured len, the state goes to DONE.
- DONE:
  - done<owner> is high for one cycle and mem_en = 0.
  - Next state is IDLE.
- Requests are not sampled in BURST or DONE.
- A requester must drop req the cycle after its gnt. A req still high on re-entry to IDLE is treated as a new request.
- Reset values: state IDLE; gnt0, gnt1, done0, done1, busy, mem_en, mem_we, owner all 0; mem_addr 0; round-robin pointer favours requester 0.
- Reset mid-burst: the burst is abandoned, no done pulse is produced, and outputs return to reset values on the next cycle.

## Timing
- req sampled at edge k: gnt and the first access occur in cycle k+1 (when hold = 0).
- An N-word burst with no hold occupies cycles k+1 through k+N. done is in cycle k+N+1 and IDLE in cycle k+N+2.
- The earliest next grant is cycle k+N+3, giving 2 dead cycles between bursts.
- Each hold cycle inside BURST extends the burst by exactly one cycle. mem_addr is held stable during hold.
- hold in IDLE or DONE has no effect.
- If hold is high in the first BURST cycle, gnt still pulses but no access occurs that cycle.

## Configuration
- BUF_CTRL_RR_EN defined: round-robin arbitration. The pointer toggles to favour the non-winner after every grant.
- BUF_CTRL_RR_EN undefined: fixed priority. Requester 0 always wins when both request, and the pointer logic is absent.
- owner and all other behaviour are identical in both builds.

## Test plan
- Single read burst: req1, addr 10, len 3, wr 0, no hold -> gnt1 in cycle k+1; mem_addr 10, 11, 12, 13 with mem_en = 1 and mem_we = 0; done1 in cycle k+5; busy low in cycle k+6.
- Wrap-around write: req0, addr 510, len 3, wr 1 -> mem_addr 510, 511, 0, 1 with mem_we = 1; done0 after 4 accesses.
- Contention:
  - Both requests held continuously, len 0 -> with BUF_CTRL_RR_EN, the grant order is 0, 1, 0, 1 with grants 3 cycles apart.
  - Without the macro, gnt0 is granted every time, as long as req0 is re-asserted.
- Hold: 4-word burst with hold high on the 2nd and 3rd BURST cycles -> 6 BURST cycles; mem_addr held during hold; exactly 4 mem_en pulses; addresses contiguous.
- Reset mid-burst: rst asserted on the 3rd access of a 512-word burst -> next cycle busy = 0, mem_en = 0, mem_addr = 0, no done pulse; a subsequent tie is granted to requester 0.
- Full-length burst: len 511 starting at addr 0 -> 512 accesses covering addresses 0 to 511; done on cycle k+513.
